// File: rtl/ts_snap_arbiter.sv
// ts_snap_arbiter: captures per-channel RTC snapshots and serializes them
// round-robin as 7-byte timestamps on a shared byte stream.
module ts_snap_arbiter #(
    parameter int NUM_CHN  = 4,
    parameter int TS_BYTES = 7
) (
    input  logic                       mclk,
    input  logic                       rst,
    input  logic [31:0]                live_sec,
    input  logic [19:0]                live_usec,
    input  logic [NUM_CHN-1:0]         snap_req,
    input  logic [NUM_CHN-1:0]         overrun_clr,
    output logic [NUM_CHN-1:0]         busy,
    output logic [NUM_CHN-1:0]         overrun,
    output logic                       ts_stb,
    output logic                       ts_valid,
    output logic [7:0]                 ts_data,
    output logic [$clog2(NUM_CHN)-1:0] ts_chn
);
    localparam int CW = $clog2(NUM_CHN);
    typedef enum logic {IDLE, SEND} state_t;
    state_t state, state_nx;
    logic [2:0] cnt, cnt_nx;
    logic [CW-1:0] grant, grant_nx, last_grant, last_grant_nx, pick, chn_nx;
    logic [NUM_CHN-1:0] pending, pending_nx, overrun_nx, fin, free;
    logic [51:0] hold [NUM_CHN];
    logic stb_nx, valid_nx, done;
    logic [7:0] data_nx;

    function automatic logic [7:0] ts_byte(input logic [51:0] h, input logic [2:0] n);
        logic [55:0] ser;
        ser = {4'b0, h[19:0], h[51:20]};
        return ser[{n, 3'b0} +: 8];
    endfunction

    // scan downward so the channel closest after last_grant wins
    always_comb begin
        pick = last_grant;
        for (int k = NUM_CHN; k >= 1; k--)
            if (pending[last_grant + CW'(k)]) pick = last_grant + CW'(k);
    end

    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        grant_nx      = grant;
        last_grant_nx = last_grant;
        stb_nx        = 1'b0;
        valid_nx      = 1'b0;
        data_nx       = 8'h00;
        chn_nx        = '0;
        done          = 1'b0;
        if (state == IDLE) begin
            if (|pending) begin
                state_nx = SEND;
                grant_nx = pick;
                cnt_nx   = 3'd0;
                stb_nx   = 1'b1;
                valid_nx = 1'b1;
                data_nx  = ts_byte(hold[pick], 3'd0);
                chn_nx   = pick;
            end
        end else if (cnt == 3'(TS_BYTES - 1)) begin
            done          = 1'b1;
            state_nx      = IDLE;
            last_grant_nx = grant;
        end else begin
            cnt_nx   = cnt + 3'd1;
            valid_nx = 1'b1;
            data_nx  = ts_byte(hold[grant], cnt + 3'd1);
            chn_nx   = grant;
        end
    end

    // a channel finishing its last byte may accept a fresh capture
    assign fin        = done ? NUM_CHN'(1) << grant : '0;
    assign free       = ~pending | fin;
    assign pending_nx = (snap_req & free) | (pending & ~fin);
    assign overrun_nx = (snap_req & ~free) | (overrun & ~overrun_clr);
    assign busy       = pending;

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 3'd0;
            grant      <= '0;
            last_grant <= CW'(NUM_CHN - 1);
            pending    <= '0;
            overrun    <= '0;
            ts_stb     <= 1'b0;
            ts_valid   <= 1'b0;
            ts_data    <= 8'h00;
            ts_chn     <= '0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            grant      <= grant_nx;
            last_grant <= last_grant_nx;
            pending    <= pending_nx;
            overrun    <= overrun_nx;
            ts_stb     <= stb_nx;
            ts_valid   <= valid_nx;
            ts_data    <= data_nx;
            ts_chn     <= chn_nx;
        end
    end

    always_ff @(posedge mclk) begin
        for (int i = 0; i < NUM_CHN; i++)
            if (snap_req[i] && free[i]) hold[i] <= {live_sec, live_usec};
    end
endmodule

// File: tb/tb_ts_snap_arbiter.sv
// tb_ts_snap_arbiter: randomized + directed scoreboard bench with a
// packet-level reference model of the snapshot arbiter.
module tb_ts_snap_arbiter;
    logic        mclk = 1'b0, rst = 1'b0;
    logic [31:0] live_sec = '0;
    logic [19:0] live_usec = '0;
    logic [3:0]  snap_req = '0, overrun_clr = '0;
    logic [3:0]  busy, overrun;
    logic        ts_stb, ts_valid;
    logic [7:0]  ts_data;
    logic [1:0]  ts_chn;

    ts_snap_arbiter dut (
        .mclk(mclk), .rst(rst), .live_sec(live_sec), .live_usec(live_usec),
        .snap_req(snap_req), .overrun_clr(overrun_clr), .busy(busy),
        .overrun(overrun), .ts_stb(ts_stb), .ts_valid(ts_valid),
        .ts_data(ts_data), .ts_chn(ts_chn)
    );

    always #5 mclk = ~mclk;

    int cyc = 0;
    always @(posedge mclk) cyc <= cyc + 1;

    typedef struct {int cyc; logic [1:0] chn; logic [7:0] data; logic stb;} byte_t;
    typedef struct {int cyc; logic [3:0] busy; logic [3:0] ovr;} st_t;
    byte_t bq[$];
    st_t   sq[$];
    int n_chk = 0, n_fail = 0;

    int send_end, sch, lastg;
    logic [3:0]  pend, ovr;
    logic [31:0] hs [4];
    logic [19:0] hu [4];

    task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        send_end = -1; sch = 0; lastg = 3; pend = '0; ovr = '0;
        bq.delete(); sq.delete();
    endtask

    // one cycle of the reference: inputs of cycle cyc, expectations for later cycles
    task automatic model_step(input logic [3:0] r, input logic [3:0] c,
                              input logic [31:0] s, input logic [19:0] u);
        int fin, pick;
        logic [3:0] np, no;
        logic [7:0] b [7];
        bit free;
        byte_t e;
        st_t st;
        fin = (send_end == cyc) ? sch : -1;
        if (cyc > send_end && pend != 0) begin
            pick = -1;
            for (int k = 1; k <= 4; k++)
                if (pick < 0 && pend[(lastg + k) % 4]) pick = (lastg + k) % 4;
            b = '{hs[pick][7:0], hs[pick][15:8], hs[pick][23:16], hs[pick][31:24],
                  hu[pick][7:0], hu[pick][15:8], {4'b0, hu[pick][19:16]}};
            for (int j = 0; j < 7; j++) begin
                e.cyc = cyc + 1 + j; e.chn = 2'(pick); e.data = b[j]; e.stb = (j == 0);
                bq.push_back(e);
            end
            send_end = cyc + 7; sch = pick; lastg = pick;
        end
        for (int i = 0; i < 4; i++) begin
            free = !pend[i] || fin == i;
            if (r[i] && free) begin
                hs[i] = s; hu[i] = u;
                np[i] = 1'b1; no[i] = ovr[i] && !c[i];
            end else if (r[i]) begin
                np[i] = pend[i]; no[i] = 1'b1;
            end else begin
                np[i] = pend[i] && fin != i; no[i] = ovr[i] && !c[i];
            end
        end
        pend = np; ovr = no;
        st.cyc = cyc + 1; st.busy = pend; st.ovr = ovr;
        sq.push_back(st);
    endtask

    always @(negedge mclk) begin : mon
        byte_t e;
        st_t s;
        if (rst) begin
            chk({ts_valid, ts_stb, ts_data, ts_chn, busy, overrun} == '0, "reset_outputs",
                {ts_valid, ts_stb, ts_data, ts_chn, busy, overrun}, 0);
        end else begin
            if (ts_valid) begin
                if (bq.size() == 0) chk(0, "unexpected_byte", {ts_chn, ts_data}, 0);
                else begin
                    e = bq.pop_front();
                    chk(e.cyc == cyc, "byte_time", 64'(cyc), 64'(e.cyc));
                    chk({ts_chn, ts_data, ts_stb} == {e.chn, e.data, e.stb}, "byte_chn_data_stb",
                        {ts_chn, ts_data, ts_stb}, {e.chn, e.data, e.stb});
                end
            end else begin
                chk({ts_stb, ts_data, ts_chn} == '0, "idle_zero", {ts_stb, ts_data, ts_chn}, 0);
                if (bq.size() != 0 && bq[0].cyc <= cyc) begin
                    e = bq.pop_front();
                    chk(0, "missing_byte", 0, {e.chn, e.data});
                end
            end
            if (sq.size() != 0 && sq[0].cyc == cyc) begin
                s = sq.pop_front();
                chk({busy, overrun} == {s.busy, s.ovr}, "busy_overrun", {busy, overrun}, {s.busy, s.ovr});
            end
        end
    end

    task automatic step(input logic [3:0] r, input logic [3:0] c);
        snap_req = r; overrun_clr = c;
        model_step(r, c, live_sec, live_usec);
        @(posedge mclk); #1;
        live_sec = live_sec + 1; live_usec = live_usec + 1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(4'b0, 4'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1; snap_req = '0; overrun_clr = '0;
        model_reset();
        @(posedge mclk); @(posedge mclk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] r, c;
        model_reset();
        #2 rst = 1'b1;
        @(posedge mclk); @(posedge mclk); #1;
        rst = 1'b0;
        live_sec = 32'h12345678; live_usec = 20'hABCDE;
        step(4'b0001, 4'b0);
        idle(12);
        step(4'b1111, 4'b0);
        idle(36);
        repeat (40) step(4'b0101, 4'b0);
        idle(20);
        step(4'b0, 4'b1111);
        step(4'b0001, 4'b0);
        step(4'b0010, 4'b0);
        step(4'b0, 4'b0);
        step(4'b0010, 4'b0);
        idle(2);
        step(4'b0, 4'b0010);
        step(4'b0010, 4'b0010);
        idle(20);
        step(4'b0, 4'b0010);
        idle(3);
        step(4'b0001, 4'b0);
        for (int k = 0; k < 20 && !(send_end == cyc && sch == 0); k++) step(4'b0, 4'b0);
        step(4'b0001, 4'b0);
        idle(20);
        step(4'b0001, 4'b0);
        for (int k = 0; k < 20 && cyc != send_end - 3; k++) step(4'b0, 4'b0);
        do_reset();
        step(4'b1000, 4'b0);
        idle(15);
        repeat (1500) begin
            live_sec = $urandom; live_usec = 20'($urandom);
            for (int i = 0; i < 4; i++) begin
                r[i] = ($urandom_range(0, 7) == 0);
                c[i] = ($urandom_range(0, 11) == 0);
            end
            step(r, c);
        end
        idle(30);
        chk(bq.size() == 0, "drain", 64'(bq.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
